// File: rtl/msad_tracker.sv
// Running minimum over per-batch SAD minima; emits the final minimum SAD and signed motion vector.
// Optional build macro MSAD_ZERO_BIAS_EN credits the (0,0) candidate by ZERO_BIAS.
module msad_tracker #(
  parameter int unsigned SAD_BIT_WIDTH   = 14,
  parameter int unsigned PIXELS_IN_BATCH = 16,
  parameter int unsigned NUM_BATCHES     = 16,
  parameter int unsigned SEARCH_RANGE    = 8,
  parameter int unsigned MV_WIDTH        = 5,
  parameter int unsigned ZERO_BIAS       = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               start_i,
  input  logic                               batch_valid_i,
  input  logic [SAD_BIT_WIDTH-1:0]           MSAD_interim,
  input  logic [$clog2(PIXELS_IN_BATCH)-1:0] MSAD_index_interim,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [SAD_BIT_WIDTH-1:0]           min_sad_o,
  output logic [MV_WIDTH-1:0]                mv_x_o,
  output logic [MV_WIDTH-1:0]                mv_y_o
);

  localparam int unsigned IDX_W = $clog2(PIXELS_IN_BATCH);
  localparam int unsigned CNT_W = $clog2(NUM_BATCHES);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         batch_cnt_q;
  logic [SAD_BIT_WIDTH-1:0] best_sad_q;
  logic [CNT_W-1:0]         best_x_q;
  logic [IDX_W-1:0]         best_y_q;

  logic                     bias_hit_c;
  logic [SAD_BIT_WIDTH-1:0] bias_c;
  logic [SAD_BIT_WIDTH-1:0] cand_c;
  logic                     take_c;
  logic                     last_c;
  logic [SAD_BIT_WIDTH-1:0] nxt_sad_c;
  logic [CNT_W-1:0]         nxt_x_c;
  logic [IDX_W-1:0]         nxt_y_c;

  // Candidate after optional zero-MV credit (saturating), and the running-min update it implies
  always_comb begin
`ifdef MSAD_ZERO_BIAS_EN
    bias_hit_c = (batch_cnt_q == CNT_W'(SEARCH_RANGE)) &&
                 (MSAD_index_interim == IDX_W'(SEARCH_RANGE));
`else
    bias_hit_c = 1'b0;
`endif
    bias_c    = bias_hit_c ? SAD_BIT_WIDTH'(ZERO_BIAS) : '0;
    cand_c    = (MSAD_interim > bias_c) ? (MSAD_interim - bias_c) : '0;
    take_c    = (cand_c < best_sad_q);
    last_c    = (batch_cnt_q == CNT_W'(NUM_BATCHES - 1));
    nxt_sad_c = take_c ? cand_c : best_sad_q;
    nxt_x_c   = take_c ? batch_cnt_q : best_x_q;
    nxt_y_c   = take_c ? MSAD_index_interim : best_y_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      batch_cnt_q <= '0;
      best_sad_q  <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      min_sad_o   <= '0;
      mv_x_o      <= '0;
      mv_y_o      <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= ACCUM;
            busy_o      <= 1'b1;
            batch_cnt_q <= '0;
            best_sad_q  <= '1;
            best_x_q    <= '0;
            best_y_q    <= '0;
          end
        end
        ACCUM: begin
          // A restart wins over a same-cycle batch and discards the partial search
          if (start_i) begin
            batch_cnt_q <= '0;
            best_sad_q  <= '1;
            best_x_q    <= '0;
            best_y_q    <= '0;
          end else if (batch_valid_i) begin
            best_sad_q  <= nxt_sad_c;
            best_x_q    <= nxt_x_c;
            best_y_q    <= nxt_y_c;
            batch_cnt_q <= batch_cnt_q + CNT_W'(1);
            if (last_c) begin
              state_q   <= DONE;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              min_sad_o <= nxt_sad_c;
              mv_x_o    <= MV_WIDTH'(nxt_x_c) - MV_WIDTH'(SEARCH_RANGE);
              mv_y_o    <= MV_WIDTH'(nxt_y_c) - MV_WIDTH'(SEARCH_RANGE);
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state_q     <= ACCUM;
            busy_o      <= 1'b1;
            batch_cnt_q <= '0;
            best_sad_q  <= '1;
            best_x_q    <= '0;
            best_y_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
